// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART ownership arbiter
package uart_pkg;

  localparam int UART_ARB_ID_WIDTH = 4;

  typedef enum logic {
    ACQUIRE = 1'b0,
    RELEASE = 1'b1
  } uart_arb_op_e;

  typedef enum logic [1:0] {
    GRANTED  = 2'd0,
    DENIED   = 2'd1,
    RELEASED = 2'd2,
    ERROR    = 2'd3
  } uart_arb_resp_e;

  typedef struct packed {
    uart_arb_op_e                 op;
    logic [UART_ARB_ID_WIDTH-1:0] id;
  } uart_arb_req_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } uart_arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// rtl/uart_rr_pick.sv - combinational round-robin first-set finder starting at start_i, wrapping
module uart_rr_pick #(
  parameter int IDX_WIDTH = 4
) (
  input  logic [(2**IDX_WIDTH)-1:0] vec_i,
  input  logic [IDX_WIDTH-1:0]      start_i,
  output logic [IDX_WIDTH-1:0]      idx_o,
  output logic                      found_o
);

  localparam int N = 2**IDX_WIDTH;

  // Scan from the far end back toward start_i so the closest set bit is written last.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[start_i + IDX_WIDTH'(i)]) begin
        found_o = 1'b1;
        idx_o   = start_i + IDX_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/uart_access_arb.sv
// rtl/uart_access_arb.sv - UART ownership arbiter with round-robin reservation for denied IDs
// Optional lease timer and reservation expiry enabled by UART_ARB_LEASE_EN.
module uart_access_arb
  import uart_pkg::*;
#(
  parameter int ID_WIDTH    = UART_ARB_ID_WIDTH,
  parameter int LEASE_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [ID_WIDTH:0]      access_id_req_i,
  input  logic                   access_id_req_valid_i,
  output logic                   access_id_req_ready_o,
  output logic [1:0]             access_id_gnt_o,
  output logic                   access_id_gnt_valid_o,
  input  logic                   access_id_gnt_ready_i,
  input  logic [LEASE_WIDTH-1:0] lease_limit_i,
  output logic                   owner_valid_o,
  output logic [ID_WIDTH-1:0]    owner_id_o,
  output logic                   lease_expired_o
);

  localparam int NUM_IDS = 2**ID_WIDTH;

  uart_arb_state_e      state_q, state_d;
  uart_arb_resp_e       code_q, code_d;
  logic                 owner_valid_q, owner_valid_d;
  logic [ID_WIDTH-1:0]  owner_id_q, owner_id_d;
  logic [NUM_IDS-1:0]   waiting_q, waiting_d;
  logic                 resv_valid_q, resv_valid_d;
  logic [ID_WIDTH-1:0]  resv_id_q, resv_id_d;
  logic                 expired_q, expired_d;

  uart_arb_op_e         req_op;
  logic [ID_WIDTH-1:0]  req_id;
  logic                 accept;
  logic                 is_owner;
  logic                 grant_new, refresh, release_ok, set_wait;
  uart_arb_resp_e       resp_code;
  logic [NUM_IDS-1:0]   id_oh, waiting_set;
  logic                 own_expire, resv_expire;
  logic                 clear_owner, reserve_trigger;
  logic [ID_WIDTH-1:0]  pick_start, pick_idx;
  logic                 pick_found;

  assign req_op = uart_arb_op_e'(access_id_req_i[ID_WIDTH]);
  assign req_id = access_id_req_i[ID_WIDTH-1:0];

`ifdef UART_ARB_LEASE_EN
  logic [LEASE_WIDTH-1:0] cnt_q, cnt_d;
  logic                   lease_active, at_limit;

  // One counter serves both an owner's lease and a pending reservation; they never coexist.
  assign lease_active = (owner_valid_q || resv_valid_q) && (lease_limit_i != '0);
  assign at_limit     = cnt_q >= (lease_limit_i - LEASE_WIDTH'(1));
`else
  logic unused_lease_limit;
  assign unused_lease_limit = ^lease_limit_i;
`endif

  // Request decode and lease events, all against pre-edge state.
  always_comb begin
    accept     = access_id_req_valid_i && access_id_req_ready_o;
    is_owner   = owner_valid_q && (owner_id_q == req_id);
    grant_new  = 1'b0;
    refresh    = 1'b0;
    release_ok = 1'b0;
    set_wait   = 1'b0;
    resp_code  = ERROR;
    if (req_op == ACQUIRE) begin
      if (!owner_valid_q && (!resv_valid_q || (resv_id_q == req_id))) begin
        resp_code = GRANTED;
        grant_new = accept;
      end else if (is_owner) begin
        resp_code = GRANTED;
        refresh   = accept;
      end else begin
        resp_code = DENIED;
        set_wait  = accept;
      end
    end else if (is_owner) begin
      resp_code  = RELEASED;
      release_ok = accept;
    end

    id_oh         = '0;
    id_oh[req_id] = 1'b1;
    waiting_set   = set_wait ? (waiting_q | id_oh) : waiting_q;

    own_expire  = 1'b0;
    resv_expire = 1'b0;
`ifdef UART_ARB_LEASE_EN
    own_expire  = owner_valid_q && lease_active && at_limit && !refresh && !release_ok;
    resv_expire = !owner_valid_q && resv_valid_q && lease_active && at_limit && !grant_new;
`endif
    clear_owner     = release_ok || own_expire;
    reserve_trigger = clear_owner || resv_expire;
    pick_start      = (clear_owner ? owner_id_q : resv_id_q) + ID_WIDTH'(1);
  end

  uart_rr_pick #(
    .IDX_WIDTH (ID_WIDTH)
  ) u_rr_pick (
    .vec_i   (waiting_set),
    .start_i (pick_start),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  always_comb begin
    state_d       = state_q;
    code_d        = code_q;
    owner_valid_d = owner_valid_q;
    owner_id_d    = owner_id_q;
    waiting_d     = waiting_set;
    resv_valid_d  = resv_valid_q;
    resv_id_d     = resv_id_q;
    expired_d     = own_expire;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_RESP;
          code_d  = resp_code;
        end
      end
      ST_RESP: begin
        if (access_id_gnt_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (grant_new) begin
      owner_valid_d     = 1'b1;
      owner_id_d        = req_id;
      waiting_d[req_id] = 1'b0;
      resv_valid_d      = 1'b0;
      resv_id_d         = '0;
    end else if (reserve_trigger) begin
      if (clear_owner) begin
        owner_valid_d = 1'b0;
        owner_id_d    = '0;
      end
      resv_valid_d = pick_found;
      resv_id_d    = pick_found ? pick_idx : '0;
      if (pick_found) begin
        waiting_d[pick_idx] = 1'b0;
      end
    end

`ifdef UART_ARB_LEASE_EN
    cnt_d = lease_active ? (cnt_q + LEASE_WIDTH'(1)) : cnt_q;
    if (grant_new || refresh || reserve_trigger) begin
      cnt_d = '0;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      code_q        <= GRANTED;
      owner_valid_q <= 1'b0;
      owner_id_q    <= '0;
      waiting_q     <= '0;
      resv_valid_q  <= 1'b0;
      resv_id_q     <= '0;
      expired_q     <= 1'b0;
`ifdef UART_ARB_LEASE_EN
      cnt_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      code_q        <= code_d;
      owner_valid_q <= owner_valid_d;
      owner_id_q    <= owner_id_d;
      waiting_q     <= waiting_d;
      resv_valid_q  <= resv_valid_d;
      resv_id_q     <= resv_id_d;
      expired_q     <= expired_d;
`ifdef UART_ARB_LEASE_EN
      cnt_q         <= cnt_d;
`endif
    end
  end

  assign access_id_req_ready_o = (state_q == ST_IDLE) && !rst_i;
  assign access_id_gnt_valid_o = (state_q == ST_RESP);
  assign access_id_gnt_o       = code_q;
  assign owner_valid_o         = owner_valid_q;
  assign owner_id_o            = owner_id_q;
  assign lease_expired_o       = expired_q;

endmodule
